// File: rtl/rapids_ctrl_pkg.sv
// Shared encodings for the instruction issue control path: FSM states,
// trap cause codes and instruction class-bit positions.
package rapids_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HALT       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_EXEC       = 3'd2,
    ST_WAIT_LOAD  = 3'd3,
    ST_WAIT_STORE = 3'd4,
    ST_TRAP       = 3'd5
  } state_t;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_IFETCH  = 2'd1;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd2;
  localparam logic [1:0] TRAP_DATA    = 2'd3;

  // Class bits counted down from the instruction MSB (IW-1 = ALU, IW-2 = PC increment).
  localparam int ALU_BIT_FROM_TOP   = 1;
  localparam int PCINC_BIT_FROM_TOP = 2;

endpackage

// File: rtl/instr_issue_ctrl_if.sv
// Instruction-memory fetch port. The master side (the issue controller) requests,
// the slave side (memory) answers with ack, data and a fault qualifier.
interface instr_issue_ctrl_if #(parameter int IW = 32);

  logic          fetch_req;
  logic          fetch_ack;
  logic [IW-1:0] fetch_data;
  logic          instr_segv;

  modport master (output fetch_req, input fetch_ack, fetch_data, instr_segv);
  modport slave  (input fetch_req, output fetch_ack, fetch_data, instr_segv);

endinterface

// File: rtl/instr_prefetch_fifo.sv
// Prefetch queue: DEPTH-entry circular buffer with push/pop/clear and a head view.
// Overflowing pushes and underflowing pops are dropped; clear wins over both.
module instr_prefetch_fifo #(
  parameter int IW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_push,
  input  logic [IW-1:0]                i_push_data,
  input  logic                         i_pop,
  input  logic                         i_clear,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic [IW-1:0]                o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [IW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push = i_push & (r_count != CW'(DEPTH)) & ~i_clear;
  assign w_pop  = i_pop  & (r_count != '0)         & ~i_clear;

  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_issue_ctrl.sv
// Issue sequencer: decouples fetch from execution via the prefetch queue and
// gates ALU/memory strobes by FSM state; records the cause of any trap.
module instr_issue_ctrl
  import rapids_ctrl_pkg::*;
#(
  parameter int IW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  instr_issue_ctrl_if.master         fetch_if,
  input  logic                       i_go,
  input  logic                       i_halt,
  input  logic                       i_flush,
  input  logic                       i_dec_invalid,
  input  logic                       i_dec_ld,
  input  logic                       i_dec_st,
  input  logic                       i_wait_data,
  input  logic                       i_data_segv,
  output logic [IW-1:0]              o_issue_instr,
  output logic                       o_issue_valid,
  output logic                       o_reg_write_en,
  output logic                       o_pc_inc,
  output logic                       o_ld,
  output logic                       o_st,
  output logic [2:0]                 o_state,
  output logic                       o_trap,
  output logic [1:0]                 o_trap_cause,
  output logic [$clog2(DEPTH+1)-1:0] o_q_count
);

  localparam int CW        = $clog2(DEPTH+1);
  localparam int PCINC_BIT = IW - PCINC_BIT_FROM_TOP;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_issue_instr;
  logic [1:0]    r_trap_cause;
  logic [1:0]    w_cause_nxt;
  logic [CW-1:0] w_count;
  logic [IW-1:0] w_head;
  logic          w_running, w_fetch_req, w_xfer, w_push, w_pop, w_clear;
  logic          w_rwe, w_pc_inc, w_ld, w_st, w_issue_valid, w_trap;

  assign w_running   = r_state inside {ST_ISSUE, ST_EXEC, ST_WAIT_LOAD, ST_WAIT_STORE};
  assign w_fetch_req = w_running & (w_count != CW'(DEPTH)) & ~i_flush;
  assign w_xfer      = w_fetch_req & fetch_if.fetch_ack;
  // flush already masks fetch_req, so a flushed word can never become a transfer.
  assign w_push      = w_xfer & ~fetch_if.instr_segv;

  assign fetch_if.fetch_req = w_fetch_req;

  instr_prefetch_fifo #(.IW(IW), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (fetch_if.fetch_data),
    .i_pop       (w_pop),
    .i_clear     (w_clear | i_flush),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_cause_nxt   = r_trap_cause;
    w_pop         = 1'b0;
    w_clear       = 1'b0;
    w_rwe         = 1'b0;
    w_pc_inc      = 1'b0;
    w_ld          = 1'b0;
    w_st          = 1'b0;
    w_issue_valid = 1'b0;
    w_trap        = 1'b0;
    case (r_state)
      ST_HALT: begin
        if (i_go) begin
          w_state_nxt = ST_ISSUE;
          w_clear     = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (i_halt) begin
          w_state_nxt = ST_HALT;
          w_clear     = 1'b1;
        end else if ((w_count != '0) && !i_flush) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_issue_valid = 1'b1;
        if (i_dec_invalid) begin
          w_state_nxt = ST_TRAP;
          w_cause_nxt = TRAP_ILLEGAL;
        end else if (i_dec_ld) begin
          w_state_nxt = ST_WAIT_LOAD;
        end else if (i_dec_st) begin
          w_state_nxt = ST_WAIT_STORE;
        end else begin
          w_rwe       = 1'b1;
          w_pc_inc    = r_issue_instr[PCINC_BIT];
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT_LOAD, ST_WAIT_STORE: begin
        w_ld = (r_state == ST_WAIT_LOAD);
        w_st = (r_state == ST_WAIT_STORE);
        if (i_data_segv) begin
          w_state_nxt = ST_TRAP;
          w_cause_nxt = TRAP_DATA;
        end else if (!i_wait_data) begin
          w_rwe       = (r_state == ST_WAIT_LOAD);
          w_pc_inc    = r_issue_instr[PCINC_BIT];
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_TRAP: begin
        w_trap = 1'b1;
        if (i_go) begin
          w_state_nxt = ST_HALT;
          w_cause_nxt = TRAP_NONE;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = ST_HALT;
    endcase
    // A faulted fetch preempts whatever the current state decided.
    if (w_xfer && fetch_if.instr_segv) begin
      w_state_nxt = ST_TRAP;
      w_cause_nxt = TRAP_IFETCH;
      w_pop       = 1'b0;
      w_clear     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_HALT;
      r_issue_instr <= '0;
      r_trap_cause  <= TRAP_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_trap_cause <= w_cause_nxt;
      if (w_pop) r_issue_instr <= w_head;
    end
  end

  assign o_issue_instr  = r_issue_instr;
  assign o_issue_valid  = w_issue_valid;
  assign o_reg_write_en = w_rwe;
  assign o_pc_inc       = w_pc_inc;
  assign o_ld           = w_ld;
  assign o_st           = w_st;
  assign o_state        = r_state;
  assign o_trap         = w_trap;
  assign o_trap_cause   = r_trap_cause;
  assign o_q_count      = w_count;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Bench for instr_issue_ctrl: per-cycle vector table plus hand sequences for
// queue fill, reset, flush and fetch-fault; issued words checked by a scoreboard.
module tb_instr_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go, halt, flush, dec_invalid, dec_ld, dec_st, wait_data, data_segv;
  logic [31:0] o_issue_instr;
  logic        o_issue_valid, o_reg_write_en, o_pc_inc, o_ld, o_st, o_trap;
  logic [2:0]  o_state;
  logic [1:0]  o_trap_cause;
  logic [2:0]  o_q_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  instr_issue_ctrl_if #(.IW(32)) fif ();

  instr_issue_ctrl #(.IW(32), .DEPTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_if       (fif),
    .i_go           (go),
    .i_halt         (halt),
    .i_flush        (flush),
    .i_dec_invalid  (dec_invalid),
    .i_dec_ld       (dec_ld),
    .i_dec_st       (dec_st),
    .i_wait_data    (wait_data),
    .i_data_segv    (data_segv),
    .o_issue_instr  (o_issue_instr),
    .o_issue_valid  (o_issue_valid),
    .o_reg_write_en (o_reg_write_en),
    .o_pc_inc       (o_pc_inc),
    .o_ld           (o_ld),
    .o_st           (o_st),
    .o_state        (o_state),
    .o_trap         (o_trap),
    .o_trap_cause   (o_trap_cause),
    .o_q_count      (o_q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: accepted fetch words queue up in order; each EXEC cycle must show the oldest.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
    end else begin
      if (o_issue_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: got %0h expected no issue", o_issue_instr);
        end else begin
          chk("issue_instr", o_issue_instr, exp_q.pop_front());
        end
      end
      if (flush || (go && (o_state == 3'd0 || o_state == 3'd5)) || (halt && o_state == 3'd1))
        exp_q.delete();
      else if (fif.fetch_req && fif.fetch_ack && !fif.instr_segv)
        exp_q.push_back(fif.fetch_data);
    end
  end

  typedef struct {
    logic        go, halt, ack;
    logic [31:0] data;
    logic        inv, ld, st, wt, dsg;
    logic [2:0]  e_state;
    logic        e_rwe, e_pci, e_ld, e_st;
    logic [1:0]  e_cause;
    logic        e_freq;
    logic [2:0]  e_qc;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic do_reset();
    @(posedge clk); #1;
    {go, halt, flush, dec_invalid, dec_ld, dec_st, wait_data, data_segv} = '0;
    fif.fetch_ack = 1'b0; fif.instr_segv = 1'b0; fif.fetch_data = '0;
    reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
  endtask

  // From HALT: start, accept nack words while the first one stalls as a load.
  task automatic fill_wl(input int nack);
    @(posedge clk); #1; go = 1'b1;
    @(posedge clk); #1; go = 1'b0; dec_ld = 1'b1; wait_data = 1'b1;
    for (int k = 0; k < nack; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      fif.fetch_ack = 1'b1; fif.fetch_data = $urandom;
    end
    @(posedge clk); #1; fif.fetch_ack = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //           go h ack data          inv ld st wt dsg  st rwe pci ld st cause freq qc
    vecs[0]  = '{0,0,0,32'h0,          0,0,0,0,0,        0,0,0,0,0,0,0,0};
    vecs[1]  = '{1,0,0,32'h0,          0,0,0,0,0,        0,0,0,0,0,0,0,0};
    vecs[2]  = '{0,0,1,32'hC000_0000,  0,0,0,0,0,        1,0,0,0,0,0,1,0};
    vecs[3]  = '{0,0,0,32'h0,          0,0,0,0,0,        1,0,0,0,0,0,1,1};
    vecs[4]  = '{0,0,0,32'h0,          0,0,0,0,0,        2,1,1,0,0,0,1,0};
    vecs[5]  = '{0,0,1,32'h8000_0001,  0,0,0,0,0,        1,0,0,0,0,0,1,0};
    vecs[6]  = '{0,0,0,32'h0,          0,0,0,0,0,        1,0,0,0,0,0,1,1};
    vecs[7]  = '{0,0,0,32'h0,          0,1,0,0,0,        2,0,0,0,0,0,1,0};
    vecs[8]  = '{0,1,0,32'h0,          0,0,0,1,0,        3,0,0,1,0,0,1,0};
    vecs[9]  = '{0,0,0,32'h0,          0,0,0,0,0,        3,1,0,1,0,0,1,0};
    vecs[10] = '{0,0,1,32'h4000_0002,  0,0,0,0,0,        1,0,0,0,0,0,1,0};
    vecs[11] = '{0,0,0,32'h0,          0,0,0,0,0,        1,0,0,0,0,0,1,1};
    vecs[12] = '{0,0,0,32'h0,          1,0,0,0,0,        2,0,0,0,0,0,1,0};
    vecs[13] = '{0,0,0,32'h0,          0,0,0,0,0,        5,0,0,0,0,2,0,0};
    vecs[14] = '{1,0,0,32'h0,          0,0,0,0,0,        5,0,0,0,0,2,0,0};
    vecs[15] = '{1,0,0,32'h0,          0,0,0,0,0,        0,0,0,0,0,0,0,0};
    vecs[16] = '{0,0,1,32'h0000_0003,  0,0,0,0,0,        1,0,0,0,0,0,1,0};
    vecs[17] = '{0,0,0,32'h0,          0,0,0,0,0,        1,0,0,0,0,0,1,1};
    vecs[18] = '{0,0,0,32'h0,          0,0,1,0,0,        2,0,0,0,0,0,1,0};
    vecs[19] = '{0,0,0,32'h0,          0,0,0,1,0,        4,0,0,0,1,0,1,0};
    vecs[20] = '{0,0,0,32'h0,          0,0,0,1,0,        4,0,0,0,1,0,1,0};
    vecs[21] = '{0,0,0,32'h0,          0,0,0,1,0,        4,0,0,0,1,0,1,0};
    vecs[22] = '{0,0,0,32'h0,          0,0,0,1,1,        4,0,0,0,1,0,1,0};
    vecs[23] = '{0,0,0,32'h0,          0,0,0,0,0,        5,0,0,0,0,3,0,0};
    vecs[24] = '{1,0,0,32'h0,          0,0,0,0,0,        5,0,0,0,0,3,0,0};
    vecs[25] = '{0,0,0,32'h0,          0,0,0,0,0,        0,0,0,0,0,0,0,0};

    reset_n = 1'b0;
    {go, halt, flush, dec_invalid, dec_ld, dec_st, wait_data, data_segv} = '0;
    fif.fetch_ack = 1'b0; fif.instr_segv = 1'b0; fif.fetch_data = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1 chk("rst_issue_instr", o_issue_instr, 32'h0);

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      go = vecs[i].go; halt = vecs[i].halt;
      fif.fetch_ack = vecs[i].ack; fif.fetch_data = vecs[i].data;
      dec_invalid = vecs[i].inv; dec_ld = vecs[i].ld; dec_st = vecs[i].st;
      wait_data = vecs[i].wt; data_segv = vecs[i].dsg;
      #1;
      chk($sformatf("v%0d_state", i), 32'(o_state),        32'(vecs[i].e_state));
      chk($sformatf("v%0d_rwe", i),   32'(o_reg_write_en), 32'(vecs[i].e_rwe));
      chk($sformatf("v%0d_pcinc", i), 32'(o_pc_inc),       32'(vecs[i].e_pci));
      chk($sformatf("v%0d_ld", i),    32'(o_ld),           32'(vecs[i].e_ld));
      chk($sformatf("v%0d_st", i),    32'(o_st),           32'(vecs[i].e_st));
      chk($sformatf("v%0d_cause", i), 32'(o_trap_cause),   32'(vecs[i].e_cause));
      chk($sformatf("v%0d_freq", i),  32'(fif.fetch_req),  32'(vecs[i].e_freq));
      chk($sformatf("v%0d_qc", i),    32'(o_q_count),      32'(vecs[i].e_qc));
      chk($sformatf("v%0d_ivld", i),  32'(o_issue_valid),  32'(vecs[i].e_state == 3'd2));
      chk($sformatf("v%0d_trap", i),  32'(o_trap),         32'(vecs[i].e_state == 3'd5));
    end

    // Queue fills to DEPTH behind a stalled load, then refills exactly once per pop.
    @(posedge clk); #1; go = 1'b1; #1;
    @(posedge clk); #1; go = 1'b0; dec_ld = 1'b1; wait_data = 1'b1;
    fif.fetch_ack = 1'b1; fif.fetch_data = $urandom; #1;
    n = 0;
    while (o_q_count != 3'd4 && n < 20) begin
      @(posedge clk); #1; fif.fetch_data = $urandom; #1;
      n++;
    end
    chk("fill_in_time", 32'(n < 20), 32'd1);
    chk("full_qc",      32'(o_q_count), 32'd4);
    chk("full_req",     32'(fif.fetch_req), 32'd0);
    chk("full_state",   32'(o_state), 32'd3);
    @(posedge clk); #1; wait_data = 1'b0; #1;
    @(posedge clk); #1; wait_data = 1'b1; #1;
    chk("pop_state", 32'(o_state), 32'd1);
    chk("pop_freq",  32'(fif.fetch_req), 32'd0);
    @(posedge clk); #1; fif.fetch_data = $urandom; #1;
    chk("refill_qc",   32'(o_q_count), 32'd3);
    chk("refill_freq", 32'(fif.fetch_req), 32'd1);
    @(posedge clk); #1; #1;
    chk("refill_done_qc", 32'(o_q_count), 32'd4);
    chk("refill_done_req", 32'(fif.fetch_req), 32'd0);
    @(posedge clk); #1; #1;
    chk("refill_once_qc", 32'(o_q_count), 32'd4);

    // Reset in the middle of a load wait with three queued words.
    do_reset();
    fill_wl(4);
    chk("pre_rst_state", 32'(o_state), 32'd3);
    chk("pre_rst_ld",    32'(o_ld), 32'd1);
    chk("pre_rst_qc",    32'(o_q_count), 32'd3);
    @(posedge clk); #1; reset_n = 1'b0; #1;
    @(posedge clk); #1; #1;
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_ld",    32'(o_ld), 32'd0);
    chk("rst_qc",    32'(o_q_count), 32'd0);
    chk("rst_freq",  32'(fif.fetch_req), 32'd0);
    reset_n = 1'b1; dec_ld = 1'b0; wait_data = 1'b0;

    // Flush with two queued words and a same-cycle ack; the acked word must vanish.
    fill_wl(3);
    chk("pre_flush_qc", 32'(o_q_count), 32'd2);
    fif.fetch_ack = 1'b1; fif.fetch_data = 32'hDEAD_BEEF; flush = 1'b1; #1;
    chk("flush_freq", 32'(fif.fetch_req), 32'd0);
    @(posedge clk); #1; flush = 1'b0; fif.fetch_ack = 1'b0; #1;
    chk("flush_qc",    32'(o_q_count), 32'd0);
    chk("flush_state", 32'(o_state), 32'd3);
    @(posedge clk); #1; wait_data = 1'b0; dec_ld = 1'b0; #1;
    @(posedge clk); #1; fif.fetch_ack = 1'b1; fif.fetch_data = 32'h1234_5678; #1;
    chk("post_flush_state", 32'(o_state), 32'd1);
    @(posedge clk); #1; fif.fetch_ack = 1'b0; #1;
    chk("post_flush_qc", 32'(o_q_count), 32'd1);
    @(posedge clk); #1; #1;
    chk("post_flush_issue", o_issue_instr, 32'h1234_5678);

    // Faulted fetch traps with cause 1 and queues nothing.
    @(posedge clk); #1; fif.fetch_ack = 1'b1; fif.instr_segv = 1'b1; fif.fetch_data = 32'h0BAD_0BAD; #1;
    chk("segv_pre_state", 32'(o_state), 32'd1);
    @(posedge clk); #1; fif.fetch_ack = 1'b0; fif.instr_segv = 1'b0; #1;
    chk("segv_state", 32'(o_state), 32'd5);
    chk("segv_cause", 32'(o_trap_cause), 32'd1);
    chk("segv_qc",    32'(o_q_count), 32'd0);
    @(posedge clk); #1; go = 1'b1; #1;
    @(posedge clk); #1; go = 1'b0; #1;
    chk("segv_ack_state", 32'(o_state), 32'd0);
    chk("segv_ack_cause", 32'(o_trap_cause), 32'd0);

    // halt is honoured in ISSUE.
    @(posedge clk); #1; go = 1'b1; #1;
    @(posedge clk); #1; go = 1'b0; halt = 1'b1; #1;
    chk("halt_pre_state", 32'(o_state), 32'd1);
    @(posedge clk); #1; halt = 1'b0; #1;
    chk("halt_state", 32'(o_state), 32'd0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
